uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised UART receiver that replaces the fixed 4x-oversampled, 8-bit, no-error-reporting receiver.
- Converts the asynchronous serial line rxd into parallel words with configurable oversampling, word width, parity and stop bits.
- Uses majority-vote sampling and reports framing, parity and overrun errors.
- Sits between the board UART pin and the CPU core's I/O port, delivering data through a valid/ready handshake.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be even and >= 4.
- DATA_BITS, 8: payload bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- SYNC_STAGES, 2: rxd synchroniser depth, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rxd  in  1  serial input; idle high.
- data_out  out  DATA_BITS  received word, LSB = first data bit on the line.
- data_valid  out  1  data_out and error flags valid; held until accepted.
- data_ready  in  1  consumer accepts when data_valid && data_ready at a rising edge.
- frame_err  out  1  a stop bit sampled low in the delivered frame.
- parity_err  out  1  parity mismatch in the delivered frame; always 0 when PARITY=0.
- overrun  out  1  sticky: at least one frame was dropped while data_valid was pending.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n low):
  - Synchroniser and 3-sample history are filled with 1.
  - FSM goes to IDLE; all counters are 0.
  - data_out=0, data_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
- Line sampling:
  - rxd passes through SYNC_STAGES flops, giving rxs.
  - A 3-entry shift history of rxs is kept.
  - The bit value is the majority of the last three rxs values at the sample cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - The first cycle with rxs=0 is T0.
  - Go to START with the bit counter loaded so that the sample point is T0 + CLKS_PER_BIT/2.
- Sample points:
  - Bit n (n=0 is the start bit) is sampled at T0 + CLKS_PER_BIT/2 + n*CLKS_PER_BIT.
  - The counter reloads CLKS_PER_BIT-1 after every sample.
- START:
  - Majority = 1 means a false start: return to IDLE, no output, no flags.
  - Otherwise go to DATA.
- DATA:
  - Shift DATA_BITS samples in LSB-first.
  - Then go to PARITY if PARITY != 0, else to STOP.
- PARITY:
  - Compare the sample against the XOR of the data bits (odd: sample must make the total count odd; even: even).
  - Record a mismatch internally.
- STOP:
  - Sample STOP_BITS bits; any 0 records a frame error.
  - After the last stop sample, the frame completes in that same cycle (Tc).
- Completion at Tc, registered in cycle Tc+1:
  - If data_valid=0, or data_valid && data_ready in cycle Tc: load data_out, frame_err, parity_err; data_valid=1.
  - Else: drop the new frame, keep the old data and flags, set overrun=1.
- Next state after completion:
  - Frame error: go to WAIT_HIGH, which stays until rxs=1, then goes to IDLE. This handles a break condition.
  - Otherwise: go to IDLE directly, so a back-to-back start edge at Tc+1 is detected.
- Handshake:
  - data_valid falls the cycle after an accept.
  - frame_err and parity_err are meaningful only while data_valid=1 and are held with the data.
  - overrun clears on the next accept.
  - Accept and completion in the same cycle: the new frame loads, data_valid stays 1, and no overrun is raised.
- Latency (8N1, CLKS_PER_BIT=16): data_valid rises at T0+153, i.e. T0 + CLKS_PER_BIT/2 + (frame_bits-1)*CLKS_PER_BIT + 1.
- Reset mid-frame: the frame is aborted, there is no output, and the block waits for a fresh falling edge. A line held low through reset release does not start a frame until rxs has returned high.
- Counters are sized to $clog2(CLKS_PER_BIT) and $clog2(DATA_BITS+1) and must never wrap during a frame.

Test Plan:
- Default params: send 0xA5 as 8N1 at 16 clk/bit, data_ready=1 → data_out=0xA5, data_valid high exactly one cycle at T0+153, all error flags 0.
- PARITY=2: send 0x3C with correct parity 0 → parity_err=0; resend with parity bit 1 → data_out=0x3C, parity_err=1.
- Stop bit forced low, then line held low for 40 bit times → data delivered with frame_err=1, busy stays high until rxd returns high, then the next frame 0x55 is received cleanly.
- Glitch: rxd low for 3 cycles then high → no data_valid, FSM back in IDLE by T0+9. Also a single-cycle 0 spike in the centre of a 1 data bit → bit still read as 1 (majority).
- data_ready=0: send 0x11 then 0x22 back-to-back → data_out=0x11, overrun=1. Raise data_ready → overrun clears; a third frame 0x33 is then received normally.
- Assert rst_n low mid-DATA of frame 0x77 → all outputs return to 0 immediately; the following frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Signal bundle between the UART receiver (master side) and the consumer of received words.
// Serial line input, valid/ready word handshake, error flags and busy status.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 rxd;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  rxd, data_ready,
        output data_out, data_valid, frame_err, parity_err, overrun, busy
    );

    modport slave (
        output rxd, data_ready,
        input  data_out, data_valid, frame_err, parity_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority-vote sampling, parity/framing/overrun
// reporting and a valid/ready output holding register.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_rx_param_if.master rx_if
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP  = BIT_W'(STOP_BITS - 1);
    localparam logic             PARITY_ODD = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic [1:0]             hist_q;
    logic                   armed_q;
    logic                   rxs;
    logic                   maj;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;

    logic [DATA_BITS-1:0]   dout_q, dout_d;
    logic                   valid_q, valid_d;
    logic                   fe_q, fe_d;
    logic                   pe_q, pe_d;
    logic                   ovr_q, ovr_d;

    logic                   done;
    logic                   done_fe;
    logic                   accept;
    logic                   load;

    // Majority over the current synchronised value and the two before it.
    assign rxs = sync_q[SYNC_STAGES-1];
    assign maj = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);

    // fill_q marks when sync_q holds real line samples; armed_q then waits for a high line
    // so a line held low through reset release cannot start a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            fill_q  <= '0;
            hist_q  <= '1;
            armed_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
            // synchroniser shifts one stage per clock regardless of statement order.
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_if.rxd};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            hist_q  <= {hist_q[0], rxs};
            armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & rxs);
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the case
        // statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        done      = 1'b0;
        done_fe   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (armed_q && !rxs) begin
                    state_d   = S_START;
                    cnt_d     = HALF_LOAD;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = FULL_LOAD;
                    state_d = maj ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = FULL_LOAD;
                    shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt_q == '0) begin
                    cnt_d   = FULL_LOAD;
                    perr_d  = (^{shreg_q, maj}) ^ PARITY_ODD;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    cnt_d = FULL_LOAD;
                    if (!maj) ferr_d = 1'b1;
                    if (bit_cnt_q == LAST_STOP) begin
                        done      = 1'b1;
                        done_fe   = ferr_q | ~maj;
                        bit_cnt_d = '0;
                        // A low stop bit may be a break; wait for the line to recover first.
                        state_d   = done_fe ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output holding register: a completed frame loads only if the slot is free or freed now.
    always_comb begin
        accept  = valid_q & rx_if.data_ready;
        load    = done & (~valid_q | accept);
        dout_d  = dout_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load) begin
            dout_d  = shreg_q;
            fe_d    = done_fe;
            pe_d    = perr_q;
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
        if (done && !load) begin
            ovr_d = 1'b1;
        end else if (accept) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift register and output word are reset too, because data_out must
            // read 0 after reset rather than whatever the datapath last held.
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_if.data_out   = dout_q;
    assign rx_if.data_valid = valid_q;
    assign rx_if.frame_err  = fe_q;
    assign rx_if.parity_err = pe_q;
    assign rx_if.overrun    = ovr_q;
    assign rx_if.busy       = (state_q != S_IDLE);
endmodule
